dcm_regfile_arbiter: RTL and testbench
======================================

# dcm_regfile_arbiter

Shares the single 128×8 motor-controller register file between several requesters: the SPI slave, the motor-channel scan FSM and the status/IRQ collector. Requester 0 has fixed high priority; the others are served round-robin. A per-requester starvation guard bounds wait time, and a bounded lock makes multi-byte accesses (24-bit positions) atomic. The memory array sits inside the block.

## Interface
- N_REQ, 3: number of requesters, 2..8; index 0 is SPI.
- ADDR_W, 7: register address width.
- DATA_W, 8: register data width.
- STARVE_LIMIT, 16: wait cycles after which a requester is starving.
- LOCK_MAX, 8: maximum cycles a lock may be held.

Ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  access request, one bit per requester.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_lock  in  N_REQ  hold the grant after this access (level).
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_ready  out  N_REQ  grant, one-hot or zero; transfer occurs when valid && ready.
- rsp_valid  out  N_REQ  one-cycle pulse: read data for requester i is present.
- rsp_rdata  out  DATA_W  read data, shared by all requesters.
- lock_timeout  out  1  one-cycle pulse on a forced lock release.

## Operation
- Arbitration is combinational from the current req_valid and registered state. At most one grant per cycle, in this order:
  1. If a lock owner exists, only the owner may be granted. All other requesters wait, including requester 0.
  2. Otherwise, grant the lowest-index starving requester (wait_cnt ≥ STARVE_LIMIT).
  3. Otherwise, grant requester 0 if it is valid.
  4. Otherwise, scan requesters 1..N_REQ-1 starting at rr_ptr, wrapping back to 1.
- Pointer update: after a grant to i ≥ 1, rr_ptr becomes i+1, wrapping to 1. A grant to requester 0 leaves rr_ptr unchanged.
- wait_cnt[i]:
  - increments when valid && !ready, saturating at STARVE_LIMIT;
  - clears on a grant to i;
  - clears when req_valid[i] drops.
- Lock acquire: a granted transfer with req_lock[i] = 1, no current owner and lock_inhibit[i] = 0 makes i the owner. lock_cnt then starts at 0.
- Lock release:
  - Normal: release when req_lock[owner] is low at a clock edge.
  - Forced: release when lock_cnt reaches LOCK_MAX-1. On a forced release:
    - lock_timeout pulses;
    - lock_inhibit[owner] sets;
    - the inhibit bit clears only when that requester deasserts req_lock.
- Lock priority: the lock overrides the starvation guard. Starving requesters keep counting and win as soon as the lock is released.
- Writes: the array is updated at the clock edge of the transfer.
- Reads: the array is read at the transfer edge. rsp_rdata and rsp_valid[i] are registered, so they are visible one cycle after the transfer.
- Read-after-write: a read of an address written in an earlier cycle returns the new value. A write and a read in the same cycle is impossible, because there is only one grant per cycle.
- Reset values: rsp_valid = 0, rsp_rdata = 0, lock_timeout = 0, owner = none, rr_ptr = 1, all wait_cnt = 0, all lock_inhibit = 0. Array contents are not reset.
- Reset during a transfer or lock: the transfer is dropped, the lock is cleared and no rsp_valid is issued. While reset is high, req_ready = 0.

## Timing
- Grant: same cycle as req_valid when no higher-priority requester contends.
- Read latency: 1 cycle from the transfer edge to rsp_valid.
- Throughput: one access per cycle.
- Requester 0 worst-case wait, with no locks: (N_REQ-1) starving grants.
- Other requesters' worst-case wait: STARVE_LIMIT + LOCK_MAX + N_REQ cycles.
- A requester must hold req_valid, req_we, req_addr and req_wdata stable until ready.

## Structure
- Shared package (dcmctrl_pkg) holds:
  - the ADDR_W/DATA_W defaults;
  - the register map constants: channel base = ch*4; flags at +0; current position at +1..+3, MSB first; speed at +64; target position at +65..+67.
- One sub-module, dcm_regfile_mem: a synchronous single-port 2^ADDR_W × DATA_W array with a registered read.
- The arbiter FSM and counters stay in the top level.

## Test plan
- Single requester 1 writes 0x5A to addr 0x03, then reads 0x03 → ready on the same cycle each time; rsp_valid[1] and rsp_rdata = 0x5A one cycle after the read.
- Requesters 0, 1 and 2 all valid continuously → requester 0 takes every grant until wait_cnt[1] hits 16; then 1 is granted, then 2; after that, 1 and 2 alternate through the starvation path.
- Requesters 1 and 2 only, valid continuously → grants alternate 1,2,1,2; rr_ptr wraps to 1.
- Requester 1 locks for 3 accesses (addr 0x01..0x03, req_lock high for the first two) while requester 0 is valid → requester 0 gets no grant until the third transfer; it is granted the cycle after.
- Requester 2 holds req_lock high with continuous requests → forced release after 8 cycles with lock_timeout high for 1 cycle; requester 0 granted next; requester 2 cannot re-lock until it drops req_lock.
- Assert reset while a lock is held and a read is in flight → no rsp_valid; all outputs 0; after reset, requester 0 is granted immediately.

Source files
------------

// File: rtl/dcmctrl_pkg.sv
// Shared motor-controller definitions: register-file geometry, register map and
// the lock-state encoding used by the register-file arbiter.
package dcmctrl_pkg;

    localparam int unsigned DCM_ADDR_W = 7;
    localparam int unsigned DCM_DATA_W = 8;

    // Register map: four bytes per channel in the low half, mirrored at +64 for targets
    localparam int unsigned REG_CH_STRIDE = 4;
    localparam int unsigned REG_FLAGS_OFS = 0;
    localparam int unsigned REG_POS_OFS   = 1;
    localparam int unsigned REG_POS_BYTES = 3;
    localparam int unsigned REG_SPEED_OFS = 64;
    localparam int unsigned REG_TGT_OFS   = 65;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    function automatic logic [DCM_ADDR_W-1:0] reg_addr(input int unsigned ch, input int unsigned ofs);
        return DCM_ADDR_W'(ch * REG_CH_STRIDE + ofs);
    endfunction

endpackage

// File: rtl/dcm_regfile_mem.sv
// Single-port register-file array: write at the access edge, registered read data
// that holds its last value until the next read.
module dcm_regfile_mem #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dcm_regfile_arbiter.sv
// Register-file arbiter: SPI (requester 0) fixed priority, round-robin among the rest,
// per-requester starvation guard and a bounded lock for atomic multi-byte accesses.
module dcm_regfile_arbiter
    import dcmctrl_pkg::*;
#(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned ADDR_W       = DCM_ADDR_W,
    parameter int unsigned DATA_W       = DCM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     lock_timeout
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_MAX + 1);

    lock_state_e        r_lock_state, w_lock_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [LCNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic               r_lock_timeout, w_timeout_nxt;
    logic [N_REQ-1:0]   r_inhibit, w_inhibit_set;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [WAIT_W-1:0]  r_wait_cnt [N_REQ];
    logic [N_REQ-1:0]   r_rsp_valid;

    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_gnt_idx;
    int                 w_rr_idx;
    logic               w_gnt_we;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [DATA_W-1:0]  w_gnt_wdata;

    // Grant selection: lock owner, then starving, then requester 0, then round-robin
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_rr_idx  = 0;
        if (!reset) begin
            if (r_lock_state == LK_HELD) begin
                w_gnt_vld = req_valid[r_owner];
                w_gnt_idx = r_owner;
            end else begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (!w_gnt_vld && req_valid[i] && (r_wait_cnt[i] >= WAIT_W'(STARVE_LIMIT))) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = IDX_W'(i);
                    end
                end
                if (!w_gnt_vld && req_valid[0]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = '0;
                end
                for (int k = 0; k < int'(N_REQ) - 1; k++) begin
                    w_rr_idx = (int'(r_rr_ptr) - 1 + k) % (int'(N_REQ) - 1) + 1;
                    if (!w_gnt_vld && req_valid[w_rr_idx]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = IDX_W'(w_rr_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        w_gnt_we    = req_we[w_gnt_idx];
        w_gnt_addr  = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        w_gnt_wdata = req_wdata[w_gnt_idx*DATA_W +: DATA_W];
    end

    // Lock FSM next state: acquire on a locked transfer, release on lock drop or timeout
    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_owner_nxt      = r_owner;
        w_lock_cnt_nxt   = r_lock_cnt;
        w_timeout_nxt    = 1'b0;
        w_inhibit_set    = '0;
        case (r_lock_state)
            LK_IDLE: begin
                if (w_gnt_vld && req_lock[w_gnt_idx] && !r_inhibit[w_gnt_idx]) begin
                    w_lock_state_nxt = LK_HELD;
                    w_owner_nxt      = w_gnt_idx;
                    w_lock_cnt_nxt   = '0;
                end
            end
            LK_HELD: begin
                if (!req_lock[r_owner]) begin
                    w_lock_state_nxt = LK_IDLE;
                end else if (r_lock_cnt == LCNT_W'(LOCK_MAX - 1)) begin
                    w_lock_state_nxt         = LK_IDLE;
                    w_timeout_nxt            = 1'b1;
                    w_inhibit_set[r_owner]   = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + LCNT_W'(1);
                end
            end
            default: w_lock_state_nxt = LK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_state   <= LK_IDLE;
            r_owner        <= '0;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_lock_state   <= w_lock_state_nxt;
            r_owner        <= w_owner_nxt;
            r_lock_cnt     <= w_lock_cnt_nxt;
            r_lock_timeout <= w_timeout_nxt;
        end
    end

    // Round-robin pointer only moves on grants to requesters 1..N_REQ-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= IDX_W'(1);
            r_rsp_valid <= '0;
        end else begin
            if (w_gnt_vld && (w_gnt_idx != '0)) begin
                r_rr_ptr <= (w_gnt_idx == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : w_gnt_idx + IDX_W'(1);
            end
            r_rsp_valid <= (w_gnt_vld && !w_gnt_we) ? req_ready : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (reset) begin
                r_wait_cnt[i] <= '0;
                r_inhibit[i]  <= 1'b0;
            end else begin
                if (!req_valid[i] || req_ready[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (r_wait_cnt[i] < WAIT_W'(STARVE_LIMIT)) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + WAIT_W'(1);
                end
                if (!req_lock[i]) begin
                    r_inhibit[i] <= 1'b0;
                end else if (w_inhibit_set[i]) begin
                    r_inhibit[i] <= 1'b1;
                end
            end
        end
    end

    dcm_regfile_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_gnt_vld),
        .i_we    (w_gnt_we),
        .i_addr  (w_gnt_addr),
        .i_wdata (w_gnt_wdata),
        .o_rdata (rsp_rdata)
    );

    assign rsp_valid    = r_rsp_valid;
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_dcm_regfile_arbiter.sv
// Bench for dcm_regfile_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the arbitration and register file.
module tb_dcm_regfile_arbiter;
    import dcmctrl_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int SL    = 16;
    localparam int LM    = 8;
    localparam int DEPTH = 128;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            lock_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    dcm_regfile_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_owner, m_lock_cnt, m_rr;
    int            m_wait [N];
    bit            m_inhib [N];
    logic [N-1:0]  m_rsp_valid;
    logic [DW-1:0] m_rdata;
    bit            m_rdata_known;
    bit            m_timeout;
    bit            mon_en = 1'b0;
    int            mon_g;
    logic [N-1:0]  mon_exp_ready;

    function automatic void model_reset();
        m_owner = -1; m_lock_cnt = 0; m_rr = 1;
        for (int i = 0; i < N; i++) begin m_wait[i] = 0; m_inhib[i] = 1'b0; end
        m_rsp_valid = '0; m_rdata = '0; m_rdata_known = 1'b1; m_timeout = 1'b0;
    endfunction

    function automatic int model_grant();
        if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++) if (req_valid[i] && m_wait[i] >= SL) return i;
        if (req_valid[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            int j = (m_rr - 1 + k) % (N - 1) + 1;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_clock(input int g);
        m_rsp_valid = '0;
        if (g >= 0) begin
            int a = int'(req_addr[g*AW +: AW]);
            if (req_we[g]) begin
                m_mem[a] = req_wdata[g*DW +: DW];
                m_known[a] = 1'b1;
            end else begin
                m_rsp_valid[g] = 1'b1;
                m_rdata = m_mem[a];
                m_rdata_known = m_known[a];
            end
            if (g >= 1) m_rr = (g == N - 1) ? 1 : g + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || i == g) m_wait[i] = 0;
            else if (m_wait[i] < SL) m_wait[i]++;
        end
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (!req_lock[m_owner]) m_owner = -1;
            else if (m_lock_cnt == LM - 1) begin
                m_timeout = 1'b1; m_inhib[m_owner] = 1'b1; m_owner = -1;
            end else m_lock_cnt++;
        end else if (g >= 0 && req_lock[g] && !m_inhib[g]) begin
            m_owner = g; m_lock_cnt = 0;
        end
        for (int i = 0; i < N; i++) if (!req_lock[i]) m_inhib[i] = 1'b0;
    endfunction

    // Cycle-by-cycle scoreboard against the model
    always @(negedge clk) begin
        if (mon_en) begin
            mon_g = reset ? -1 : model_grant();
            mon_exp_ready = '0;
            if (mon_g >= 0) mon_exp_ready[mon_g] = 1'b1;
            n_checks++;
            if (req_ready !== mon_exp_ready) begin
                n_fail++; $display("FAIL model_ready t=%0t got=%b exp=%b", $time, req_ready, mon_exp_ready);
            end
            n_checks++;
            if (rsp_valid !== m_rsp_valid) begin
                n_fail++; $display("FAIL model_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, m_rsp_valid);
            end
            if (m_rdata_known) begin
                n_checks++;
                if (rsp_rdata !== m_rdata) begin
                    n_fail++; $display("FAIL model_rdata t=%0t got=%h exp=%h", $time, rsp_rdata, m_rdata);
                end
            end
            n_checks++;
            if (lock_timeout !== m_timeout) begin
                n_fail++; $display("FAIL model_timeout t=%0t got=%b exp=%b", $time, lock_timeout, m_timeout);
            end
            if (reset) model_reset();
            else model_clock(mon_g);
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
        req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        next_edge();
        reset = 1'b1;
        clear_reqs();
        next_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== '0 || rsp_rdata !== '0 || lock_timeout !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h to=%b rdy=%b exp all zero", rsp_valid, rsp_rdata, lock_timeout, req_ready);
        end
    endtask

    task automatic test_single_rw();
        next_edge(); set_req(1, 1, 1, 0, 7'h03, 8'h5A);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_wr_ready got=%b exp=010", req_ready); end
        next_edge(); set_req(1, 1, 0, 0, 7'h03, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_rd_ready got=%b exp=010", req_ready); end
        next_edge(); set_req(1, 0, 0, 0, 7'h00, 8'h00);
        @(negedge clk); n_checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL single_rd_data got v=%b d=%h exp v=010 d=5a", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [N-1:0] exp;
        int p;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 7'h03, 8'h00);
        for (int t = 0; t < 52; t++) begin
            @(negedge clk);
            p = (t - 18) % 17;
            if (t < 16) exp = 3'b001;
            else if (t == 16) exp = 3'b010;
            else if (t == 17) exp = 3'b100;
            else exp = (p < 15) ? 3'b001 : (p == 15) ? 3'b010 : 3'b100;
            n_checks++;
            if (req_ready !== exp) begin n_fail++; $display("FAIL starve_grant t=%0d got=%b exp=%b", t, req_ready, exp); end
        end
        next_edge(); clear_reqs();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        set_req(1, 1, 0, 0, 7'h03, 8'h00);
        set_req(2, 1, 0, 0, 7'h04, 8'h00);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            exp = (t % 2 == 0) ? 3'b010 : 3'b100;
            n_checks++;
            if (req_ready !== exp) begin n_fail++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, req_ready, exp); end
        end
        next_edge(); clear_reqs();
    endtask

    task automatic test_lock();
        do_reset();
        set_req(1, 1, 1, 1, reg_addr(0, REG_POS_OFS), 8'h11);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL lock_acquire got=%b exp=010", req_ready); end
        next_edge();
        set_req(0, 1, 0, 0, 7'h03, 8'h00);
        set_req(1, 1, 1, 1, reg_addr(0, REG_POS_OFS + 1), 8'h22);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL lock_hold got=%b exp=010", req_ready); end
        next_edge(); set_req(1, 1, 1, 0, reg_addr(0, REG_POS_OFS + 2), 8'h33);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL lock_last got=%b exp=010", req_ready); end
        next_edge(); set_req(1, 0, 0, 0, 7'h00, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL lock_release_grant got=%b exp=001", req_ready); end
        next_edge(); set_req(1, 1, 0, 0, reg_addr(0, REG_POS_OFS + 1), 8'h00); set_req(0, 0, 0, 0, 7'h00, 8'h00);
        next_edge(); clear_reqs();
        @(negedge clk); n_checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 8'h22) begin
            n_fail++; $display("FAIL lock_readback got v=%b d=%h exp v=010 d=22", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        set_req(2, 1, 0, 1, 7'h05, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b100) begin n_fail++; $display("FAIL to_acquire got=%b exp=100", req_ready); end
        next_edge(); set_req(0, 1, 0, 0, 7'h03, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); n_checks++;
            if (req_ready !== 3'b100 || lock_timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_held c=%0d got rdy=%b to=%b exp rdy=100 to=0", c, req_ready, lock_timeout);
            end
        end
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b001 || lock_timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_forced got rdy=%b to=%b exp rdy=001 to=1", req_ready, lock_timeout);
        end
        next_edge(); set_req(0, 0, 0, 0, 7'h00, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b100 || lock_timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse_end got rdy=%b to=%b exp rdy=100 to=0", req_ready, lock_timeout);
        end
        next_edge(); set_req(0, 1, 0, 0, 7'h03, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL to_no_relock got=%b exp=001", req_ready); end
        next_edge(); set_req(0, 0, 0, 0, 7'h00, 8'h00); set_req(2, 1, 0, 0, 7'h05, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b100) begin n_fail++; $display("FAIL to_drop_lock got=%b exp=100", req_ready); end
        next_edge(); set_req(2, 1, 0, 1, 7'h05, 8'h00);
        @(negedge clk);
        next_edge(); set_req(0, 1, 0, 0, 7'h03, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b100) begin n_fail++; $display("FAIL to_relock_hold got=%b exp=100", req_ready); end
        next_edge(); clear_reqs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_req(1, 1, 1, 1, 7'h05, 8'h77);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rst_lock_acq got=%b exp=010", req_ready); end
        next_edge(); reset = 1'b1; set_req(1, 1, 0, 1, 7'h05, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready_low got=%b exp=000", req_ready); end
        next_edge(); reset = 1'b0; set_req(0, 1, 0, 0, 7'h05, 8'h00);
        @(negedge clk); n_checks++;
        if (req_ready !== 3'b001 || rsp_valid !== '0 || rsp_rdata !== '0 || lock_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after got rdy=%b v=%b d=%h to=%b exp rdy=001 v=000 d=00 to=0", req_ready, rsp_valid, rsp_rdata, lock_timeout);
        end
        next_edge(); clear_reqs();
    endtask

    task automatic test_random(input int cycles);
        logic [N-1:0] done;
        logic [N-1:0] lk;
        done = '1;
        lk = '0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || done[i]) begin
                    req_valid[i] = ($urandom % 3) != 0;
                    req_we[i]    = $urandom % 2;
                    req_addr[i*AW +: AW]  = AW'($urandom % 16);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                end
                if ($urandom % 8 == 0) lk[i] = ~lk[i];
                req_lock[i] = lk[i];
            end
            @(negedge clk);
            done = req_valid & req_ready;
            next_edge();
        end
        clear_reqs();
        @(negedge clk);
    endtask

    initial begin
        clear_reqs();
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        next_edge();
        reset = 1'b0;
        test_reset();
        test_single_rw();
        test_starvation();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_reset_inflight();
        test_random(1500);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
